// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads imem over req/ack and
// presents each word to decode over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [5:0]        instr_op_o,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        DROP
    } state_e;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_e            state_q;
    logic              req_q;
    logic              valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [ADDR_W-1:0] tgt_q;

    logic              ack_v;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] pc_inc;

    // An ack only counts while a request is actually on the bus
    assign ack_v    = imem_ack_i & req_q;
    assign redir_pc = redirect_pc_i & ALIGN_MASK;
    assign pc_inc   = pc_q + ADDR_W'(4);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= REQ;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            tgt_q    <= '0;
        end else begin
            unique case (state_q)
                REQ: begin
                    if (redirect_i) begin
                        // Nothing in flight (or it just completed): retarget now
                        if (ack_v || !req_q) begin
                            pc_q  <= redir_pc;
                            req_q <= 1'b1;
                        end else begin
                            tgt_q   <= redir_pc;
                            state_q <= DROP;
                        end
                    end else if (ack_v) begin
                        instr_q  <= imem_rdata_i;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_inc;
                        req_q    <= 1'b0;
                        state_q  <= HOLD;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        valid_q <= 1'b0;
                        pc_q    <= redir_pc;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end else if (instr_ready_i) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                DROP: begin
                    if (ack_v) begin
                        pc_q    <= redirect_i ? redir_pc : tgt_q;
                        state_q <= REQ;
                    end else if (redirect_i) begin
                        tgt_q <= redir_pc;
                    end
                end
                default: begin
                    state_q <= REQ;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_op_o    = instr_q[31:26];
    assign pc_o          = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency imem responder.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [5:0]  instr_op;
    logic [31:0] pc_out;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    int ncmp = 0;
    int nfail = 0;
    int lat = 0;
    int cnt = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_op_o    (instr_op),
        .pc_o          (pc_out),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[7:2], 2'b11, a[23:0]};
    endfunction

    // Responder: ack after lat cycles of a continuous request
    always @(posedge clk) begin
        if (!rst || !imem_req || imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end
    assign imem_ack   = imem_req && (cnt >= lat);
    assign imem_rdata = memw(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_instr(input string tag, input logic [31:0] a);
        logic [31:0] w;
        w = memw(a);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
        chk({tag, ".pc"}, pc_out, a);
        chk({tag, ".instr"}, instr, w);
        chk({tag, ".op"}, 32'(instr_op), {26'd0, w[31:26]});
    endtask

    initial begin
        // 1: reset and zero-latency streaming
        tick();
        tick();
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.valid", 32'(instr_valid), 32'd0);
        chk("rst.instr", instr, 32'd0);
        chk("rst.pc", pc_out, 32'd0);
        rst = 1'b1;
        chk("rel.req", 32'(imem_req), 32'd0);
        tick();
        chk("t1.req0", 32'(imem_req), 32'd1);
        chk("t1.addr0", imem_addr, 32'h0);
        chk("t1.nv0", 32'(instr_valid), 32'd0);
        tick();
        chk_instr("t1.i0", 32'h0);
        tick();
        chk("t1.nv1", 32'(instr_valid), 32'd0);
        chk("t1.addr4", imem_addr, 32'h4);
        tick();
        chk_instr("t1.i4", 32'h4);
        tick();
        chk("t1.addr8", imem_addr, 32'h8);
        tick();
        chk_instr("t1.i8", 32'h8);

        // 2: latency 3, decode stalls in HOLD
        instr_ready = 1'b0;
        lat = 3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2.hold8.valid", 32'(instr_valid), 32'd1);
            chk("t2.hold8.pc", pc_out, 32'h8);
            chk("t2.hold8.req", 32'(imem_req), 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2.wait.req", 32'(imem_req), 32'd1);
            chk("t2.wait.addr", imem_addr, 32'hC);
            chk("t2.wait.nv", 32'(instr_valid), 32'd0);
            tick();
        end
        chk("t2.ack.addr", imem_addr, 32'hC);
        tick();
        chk_instr("t2.iC", 32'hC);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2.holdC.pc", pc_out, 32'hC);
            chk("t2.holdC.instr", instr, memw(32'hC));
            chk("t2.holdC.req", 32'(imem_req), 32'd0);
        end

        // 3: redirect in HOLD with ready=1 drops the word
        lat = 0;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        instr_ready = 1'b0;
        chk("t3.nv", 32'(instr_valid), 32'd0);
        chk("t3.req", 32'(imem_req), 32'd1);
        chk("t3.addr", imem_addr, 32'h40);
        tick();
        chk_instr("t3.i40", 32'h40);

        // 4: redirects while a read is outstanding
        lat = 4;
        redirect = 1'b1;
        redirect_pc = 32'h10;
        tick();
        chk("t4.addr10", imem_addr, 32'h10);
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        chk("t4.drop.addr", imem_addr, 32'h10);
        chk("t4.drop.nv", 32'(instr_valid), 32'd0);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h90;
        chk("t4.drop2.addr", imem_addr, 32'h10);
        tick();
        redirect = 1'b0;
        chk("t4.drop3.addr", imem_addr, 32'h10);
        chk("t4.drop3.req", 32'(imem_req), 32'd1);
        chk("t4.drop3.nv", 32'(instr_valid), 32'd0);
        tick();
        chk("t4.ack.addr", imem_addr, 32'h10);
        chk("t4.ack.nv", 32'(instr_valid), 32'd0);
        lat = 0;
        tick();
        chk("t4.new.addr", imem_addr, 32'h90);
        chk("t4.new.nv", 32'(instr_valid), 32'd0);
        tick();
        chk_instr("t4.i90", 32'h90);

        // 5: PC wrap and misaligned redirect target
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        instr_ready = 1'b1;
        chk("t5.addrTop", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk_instr("t5.iTop", 32'hFFFF_FFFC);
        tick();
        chk("t5.wrap.addr", imem_addr, 32'h0);
        chk("t5.wrap.nv", 32'(instr_valid), 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        instr_ready = 1'b0;
        chk("t5.addr100", imem_addr, 32'h100);
        chk("t5.nv", 32'(instr_valid), 32'd0);
        tick();
        chk_instr("t5.i100", 32'h100);

        // 6: async reset mid-HOLD and mid-read
        #2;
        rst = 1'b0;
        #1;
        chk("t6.h.req", 32'(imem_req), 32'd0);
        chk("t6.h.valid", 32'(instr_valid), 32'd0);
        chk("t6.h.instr", instr, 32'd0);
        chk("t6.h.pc", pc_out, 32'd0);
        chk("t6.h.addr", imem_addr, 32'h0);
        rst = 1'b1;
        lat = 5;
        tick();
        chk("t6.r.req", 32'(imem_req), 32'd1);
        tick();
        chk("t6.r.addr", imem_addr, 32'h0);
        chk("t6.r.nv", 32'(instr_valid), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6.r.req0", 32'(imem_req), 32'd0);
        chk("t6.r.valid0", 32'(instr_valid), 32'd0);
        rst = 1'b1;
        lat = 0;
        instr_ready = 1'b1;
        tick();
        chk("t6.restart.req", 32'(imem_req), 32'd1);
        chk("t6.restart.addr", imem_addr, 32'h0);
        tick();
        chk_instr("t6.i0", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
